// File: rtl/axi4_stream_arbiter_if.sv
// AXI4-Stream channel bundle shared by the arbiter's source and master ports.
// master drives the stream, slave consumes it.
interface axi4_stream_arbiter_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int TKEEP_WIDTH = 4
);
   logic                   TVALID;
   logic                   TREADY;
   logic [DATA_WIDTH-1:0]  TDATA;
   logic [TKEEP_WIDTH-1:0] TKEEP;
   logic                   TLAST;
   logic [1:0]             TDEST;
   logic [7:0]             TID;

   modport master (
      output TVALID,
      output TDATA,
      output TKEEP,
      output TLAST,
      output TDEST,
      output TID,
      input  TREADY
   );

   modport slave (
      input  TVALID,
      input  TDATA,
      input  TKEEP,
      input  TLAST,
      output TREADY
   );
endinterface

// File: rtl/axi4_stream_arbiter.sv
// Two-input packet-granular round-robin AXI4-Stream arbiter.
// Grants move only after a TLAST beat; TDEST carries the source index.
module axi4_stream_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int TKEEP_WIDTH = 4
) (
   input  logic                        ACLK,
   input  logic                        RSTN,
   input  logic                        EN,
   axi4_stream_arbiter_if.slave        S0,
   axi4_stream_arbiter_if.slave        S1,
   axi4_stream_arbiter_if.master       M,
   output logic [1:0]                  GRANT,
   output logic                        BUSY,
   output logic [31:0]                 PKT_CNT0,
   output logic [31:0]                 PKT_CNT1
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        last_q, last_d;
   logic [31:0] cnt0_q, cnt0_d;
   logic [31:0] cnt1_q, cnt1_d;

   logic                   vld;
   logic                   lst;
   logic [DATA_WIDTH-1:0]  data_sel;
   logic [TKEEP_WIDTH-1:0] keep_sel;
   logic                   rdy0;
   logic                   rdy1;
   logic [1:0]             dest;
   logic [1:0]             grant;

   always_ff @(posedge ACLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
      end
   end

   // Both valid: serve the source that did not own the last packet.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;
      unique case (state_q)
         IDLE: begin
            if (EN) begin
               if (S0.TVALID && S1.TVALID) begin
                  state_d = last_q ? GNT0 : GNT1;
               end else if (S0.TVALID) begin
                  state_d = GNT0;
               end else if (S1.TVALID) begin
                  state_d = GNT1;
               end
            end
         end
         GNT0: begin
            if (S0.TVALID && M.TREADY && S0.TLAST) begin
               state_d = IDLE;
               last_d  = 1'b0;
               cnt0_d  = cnt0_q + 32'd1;
            end
         end
         GNT1: begin
            if (S1.TVALID && M.TREADY && S1.TLAST) begin
               state_d = IDLE;
               last_d  = 1'b1;
               cnt1_d  = cnt1_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      vld      = 1'b0;
      lst      = 1'b0;
      data_sel = '0;
      keep_sel = '0;
      rdy0     = 1'b0;
      rdy1     = 1'b0;
      dest     = 2'd0;
      grant    = 2'b00;
      unique case (state_q)
         GNT0: begin
            vld      = S0.TVALID;
            lst      = S0.TLAST;
            data_sel = S0.TDATA;
            keep_sel = S0.TKEEP;
            rdy0     = M.TREADY;
            grant    = 2'b01;
         end
         GNT1: begin
            vld      = S1.TVALID;
            lst      = S1.TLAST;
            data_sel = S1.TDATA;
            keep_sel = S1.TKEEP;
            rdy1     = M.TREADY;
            dest     = 2'd1;
            grant    = 2'b10;
         end
         default: ;
      endcase
   end

   assign M.TVALID  = vld;
   assign M.TLAST   = lst;
   assign M.TDATA   = data_sel;
   assign M.TKEEP   = keep_sel;
   assign M.TDEST   = dest;
   assign M.TID     = 8'd0;
   assign S0.TREADY = rdy0;
   assign S1.TREADY = rdy1;
   assign GRANT     = grant;
   assign BUSY      = |grant;
   assign PKT_CNT0  = cnt0_q;
   assign PKT_CNT1  = cnt1_q;

endmodule

// File: doc/axi4_stream_arbiter.md
# axi4_stream_arbiter

Packet-granular, two-input round-robin arbiter that shares one AXI4-Stream master port between two stream sources in the PolarFire SoC fabric demo. Grants switch only on packet boundaries, after a TLAST beat is accepted. Each packet is tagged with its source index on TDEST. Per-source packet counts are exposed for software and bench visibility.

## Interface
- DATA_WIDTH, 32: TDATA width in bits.
- TKEEP_WIDTH, 4: TKEEP width; equals DATA_WIDTH/8.
- ACLK  input  1  single clock; all logic rising-edge.
- RSTN  input  1  asynchronous, active-low reset.
- EN  input  1  arbitration enable; sampled only in IDLE.
- S0_TVALID / S1_TVALID  input  1  source valid.
- S0_TREADY / S1_TREADY  output  1  source ready.
- S0_TDATA / S1_TDATA  input  DATA_WIDTH  source data.
- S0_TKEEP / S1_TKEEP  input  TKEEP_WIDTH  source byte keep.
- S0_TLAST / S1_TLAST  input  1  source end of packet.
- M_TVALID  output  1  master valid.
- M_TREADY  input  1  downstream ready.
- M_TDATA  output  DATA_WIDTH  master data.
- M_TKEEP  output  TKEEP_WIDTH  master keep.
- M_TLAST  output  1  master end of packet.
- M_TDEST  output  2  granted source index: 2'd0 or 2'd1.
- M_TID  output  8  constant 8'b0.
- GRANT  output  2  one-hot grant; bit n = source n owns the master port.
- BUSY  output  1  high when not in IDLE.
- PKT_CNT0 / PKT_CNT1  output  32  packets completed per source.

## Operation
- FSM states: IDLE, GNT0, GNT1. Reset state is IDLE.
- Registered state: FSM, last_served pointer (reset = 1), PKT_CNT0, PKT_CNT1.
- IDLE:
  - If EN=1 and exactly one Sn_TVALID=1, go to GNTn.
  - If EN=1 and both valid, go to GNT of the source != last_served. After reset, S0 wins.
  - If EN=0 or no valid, stay in IDLE.
- GNTn, combinational routing:
  - M_TVALID=Sn_TVALID; M_TDATA/M_TKEEP/M_TLAST = Sn values; Sn_TREADY=M_TREADY.
  - The other source's TREADY=0.
- GNTn exit: on the M_TVALID & M_TREADY & M_TLAST cycle, go to IDLE, set last_served=n, and increment PKT_CNTn.
- EN is ignored inside GNTn. A packet in progress always completes; EN=0 only blocks the next grant.
- Outside GNT states: M_TVALID=0, M_TDATA=0, M_TKEEP=0, M_TLAST=0, both Sn_TREADY=0, and M_TDEST holds 0.
- M_TDEST = n while in GNTn.
- GRANT = 2'b01 in GNT0, 2'b10 in GNT1, 2'b00 in IDLE.
- PKT_CNTn wraps from 32'hFFFF_FFFF to 0 silently.
- Source valid dropping mid-packet (AXI violation by source): M_TVALID follows it low; the grant is held and no timeout applies.
- Reset mid-packet:
  - All outputs go to reset values immediately (asynchronous), and the FSM returns to IDLE.
  - Counters clear to 0 and last_served returns to 1.
  - The partial packet is not counted and is not resumed.

## Timing
- Reset values: every output 0, except that the internal last_served=1.
- Grant latency: 1 cycle. A valid sampled in IDLE at edge k gives GNT at edge k+1, and the first beat can transfer in the cycle after edge k+1.
- Data path in GNT is pure combinational pass-through with zero added latency. TVALID/TREADY follow AXI4-Stream rules.
- Inter-packet gap: exactly 1 IDLE cycle after every TLAST transfer, even if the same or other source is already valid.
- A single-beat packet (TLAST on the first beat) occupies 1 GNT cycle plus 1 IDLE cycle when M_TREADY=1.
- PKT_CNTn and last_served update on the same edge that leaves GNTn.
- BUSY equals |GRANT.

## Test plan
- Reset, then S0 sends a 4-beat packet with M_TREADY=1 -> GRANT=01 one cycle after valid; 4 beats pass with TDEST=0; TLAST on beat 4; PKT_CNT0=1; GRANT=00 for 1 cycle.
- S0 and S1 both valid continuously, 3-beat packets each -> grants alternate S0, S1, S0, S1; each packet is followed by exactly 1 IDLE cycle; after 4 packets PKT_CNT0=2 and PKT_CNT1=2.
- S1 packet with M_TREADY toggling 1,0,1,0 -> beats only transfer when M_TREADY=1; S1_TREADY mirrors M_TREADY; S0_TREADY=0 throughout; data order preserved.
- EN dropped to 0 mid-packet on S1 -> packet completes normally and PKT_CNT1 increments; the FSM stays in IDLE while S0 is valid until EN=1, then grants S0.
- RSTN asserted on beat 2 of a 5-beat S0 packet -> M_TVALID=0 and GRANT=00 asynchronously; PKT_CNT0=0; after release, with both sources valid, S0 is granted first.
- PKT_CNT1 driven to 32'hFFFF_FFFF (force/deposit), then one S1 packet -> PKT_CNT1=0 and PKT_CNT0 is unchanged.
